// File: rtl/brpred_pkg.sv
// ---------------------------------------------------------------------------
// brpred_pkg
// Shared definitions for the branch prediction/resolution unit:
//   - RISC-V branch funct3 encodings
//   - 2-bit saturating counter type and its states
//   - counter reset value
//   - helper that recognises the legal branch funct3 encodings
// ---------------------------------------------------------------------------
package brpred_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = CTR_WEAK_NT;

    // 010 and 011 are the only non-branch encodings.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/bht_ctr_update.sv
// ---------------------------------------------------------------------------
// bht_ctr_update
// Combinational next state of one 2-bit saturating branch counter.
// Ports:
//   ctr_i   : current counter value
//   taken_i : resolved branch outcome (1 = taken)
//   ctr_o   : counter value after training, saturating at 00 / 11
// ---------------------------------------------------------------------------
module bht_ctr_update
    import brpred_pkg::*;
(
    input  bht_ctr_t ctr_i,
    input  logic     taken_i,
    output bht_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            CTR_STRONG_NT: ctr_o = taken_i ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   ctr_o = taken_i ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    ctr_o = taken_i ? CTR_STRONG_T : CTR_WEAK_NT;
            CTR_STRONG_T:  ctr_o = taken_i ? CTR_STRONG_T : CTR_WEAK_T;
            default:       ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/brpred_unit.sv
// ---------------------------------------------------------------------------
// brpred_unit
// Branch prediction and resolution unit. A tagless table of 2-bit
// saturating counters indexed by pc[IDX_W+1:2] gives fetch a combinational
// taken/not-taken prediction. Execute returns comparator results; the unit
// decodes the real outcome, trains the table and raises a one-cycle
// registered redirect on a mispredict.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   fetch_pc_i              : fetch PC          -> pred_taken_o (comb)
//   resolve_valid_i/pc/target/funct3/pred : resolving branch from execute
//   br_unsigned_o           : comparator signedness select (comb, funct3[1])
//   br_less_i, br_equal_i   : comparator results
//   redirect_o, redirect_pc_o : registered mispredict flush + correct PC
//   stat_branches_o, stat_mispredicts_o : saturating event counters
//
// Optional feature: define BRPRED_STATS_EN to build the statistics
// counters; otherwise both stat outputs are tied to zero.
// ---------------------------------------------------------------------------
module brpred_unit
    import brpred_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic [31:0] resolve_target_i,
    input  logic [2:0]  resolve_funct3_i,
    input  logic        resolve_pred_i,
    output logic        br_unsigned_o,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
);

    // Counters live in flops rather than block RAM: the whole table must
    // clear in one reset cycle and the lookup is combinational.
    bht_ctr_t r_table [ENTRIES];

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_upd_idx;
    bht_ctr_t         w_upd_ctr;
    bht_ctr_t         w_ctr_next;
    logic             w_taken;
    logic             w_upd_en;
    logic             w_mispredict;

    logic             r_redirect;
    logic [31:0]      r_redirect_pc;

    assign w_fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign w_upd_idx   = resolve_pc_i[IDX_W+1:2];

    // Lookup sees the pre-update value on an index collision (no bypass).
    assign pred_taken_o  = r_table[w_fetch_idx][1];
    assign br_unsigned_o = resolve_funct3_i[1];

    always_comb begin
        w_taken = 1'b0;
        case (resolve_funct3_i)
            F3_BEQ:           w_taken = br_equal_i;
            F3_BNE:           w_taken = !br_equal_i;
            F3_BLT, F3_BLTU:  w_taken = br_less_i;
            F3_BGE, F3_BGEU:  w_taken = !br_less_i;
            default:          w_taken = 1'b0;
        endcase
    end

    assign w_upd_en     = resolve_valid_i && f3_is_legal(resolve_funct3_i);
    assign w_mispredict = w_upd_en && (w_taken != resolve_pred_i);
    assign w_upd_ctr    = r_table[w_upd_idx];

    bht_ctr_update u_ctr_update (
        .ctr_i   (w_upd_ctr),
        .taken_i (w_taken),
        .ctr_o   (w_ctr_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= BHT_RESET;
            end
        end else if (w_upd_en) begin
            r_table[w_upd_idx] <= w_ctr_next;
        end
    end

    // Redirect is a single-cycle pulse; the PC is held between pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? resolve_target_i
                                         : (resolve_pc_i + 32'd4);
            end
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;

`ifdef BRPRED_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (w_upd_en && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches_o    = r_stat_branches;
    assign stat_mispredicts_o = r_stat_mispredicts;
`else
    assign stat_branches_o    = 32'd0;
    assign stat_mispredicts_o = 32'd0;
`endif

    // PC bits outside the index field do not affect lookup.
    logic w_unused;
    assign w_unused = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

endmodule

// File: doc/brpred_unit.md
# brpred_unit

Branch prediction and resolution unit for the pipelined core. Fetch reads a table of 2-bit saturating counters indexed by PC and gets a combinational taken/not-taken prediction. Execute sends the branch comparator's `br_less`/`br_equal` results back with funct3. The unit then:
- decides the actual outcome,
- drives the comparator's signedness select,
- trains the table,
- issues a registered mispredict redirect.

## Interface
Parameters:
- `ENTRIES`, 64: number of counter entries; power of two, 4..1024.
- `IDX_W`, `$clog2(ENTRIES)`: derived index width; not overridden.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `fetch_pc_i` in 32: fetch-stage PC.
- `pred_taken_o` out 1: prediction for `fetch_pc_i`, combinational.
- `resolve_valid_i` in 1: execute stage holds a branch this cycle.
- `resolve_pc_i` in 32: PC of the resolving branch.
- `resolve_target_i` in 32: branch target computed by the ALU.
- `resolve_funct3_i` in 3: branch funct3.
- `resolve_pred_i` in 1: prediction carried down the pipe with the branch.
- `br_unsigned_o` out 1: signedness select to the branch comparator.
- `br_less_i` in 1: comparator less-than result.
- `br_equal_i` in 1: comparator equal result.
- `redirect_o` out 1: registered; mispredict, flush and redirect fetch.
- `redirect_pc_o` out 32: registered; correct next PC.
- `stat_branches_o` out 32: resolved-branch count (see Configuration).
- `stat_mispredicts_o` out 32: mispredict count (see Configuration).

## Operation
- **Index:** `pc[IDX_W+1:2]` for both lookup and update. There is no tag; aliasing is accepted.
- **Prediction:** `pred_taken_o = counter[idx][1]`.
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Signedness select:** `br_unsigned_o = resolve_funct3_i[1]`, combinational. It is valid regardless of `resolve_valid_i`.
- **Actual outcome** (`taken`), decoded from funct3:
  - 000 BEQ: `eq`.
  - 001 BNE: `!eq`.
  - 100 BLT and 110 BLTU: `less`.
  - 101 BGE and 111 BGEU: `!less`.
  - 010 and 011 are illegal. When `resolve_valid_i` is high with an illegal funct3, the cycle is ignored: no training, no redirect, no stats.
- **Training** on a legal resolve, at the clock edge:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- **Mispredict** means `taken != resolve_pred_i`.
  - Next cycle: `redirect_o` = 1.
  - `redirect_pc_o` = `resolve_target_i` if taken, else `resolve_pc_i + 4`. The addition is 32-bit and wraps (0xFFFFFFFC + 4 = 0x00000000).
- **Lookup/update collision:** same index in the same cycle, no bypass. `pred_taken_o` reflects the pre-update counter.

## Timing
- Prediction: 0-cycle latency, combinational from `fetch_pc_i` and the table.
- Counter update: visible to lookup 1 cycle after the resolve cycle.
- `redirect_o` and `redirect_pc_o`: registered, asserted exactly 1 cycle after a mispredicting resolve, and held for 1 cycle only.
  - Back-to-back mispredicts give consecutive 1-cycle pulses, each carrying its own PC.
- Reset values:
  - All counters 01 (weak-NT).
  - `redirect_o` = 0.
  - `redirect_pc_o` = 0.
  - Stats = 0.
- Reset during a resolve cycle: reset wins. There is no training and no redirect on the following cycle.
- The table reset clears all entries in a single cycle.

## Configuration
- Macro: `BRPRED_STATS_EN`.
- Defined:
  - `stat_branches_o` increments on each legal resolve.
  - `stat_mispredicts_o` increments on each mispredict.
  - Both are 32-bit saturating at 0xFFFFFFFF and cleared by `rst_i`.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- **Shared package `brpred_pkg`:**
  - funct3 constants `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - 2-bit counter typedef `bht_ctr_t` with state constants.
  - Reset constant `BHT_RESET = 2'b01`.
- **Sub-module `bht_ctr_update`:** combinational saturating next-state for one counter from (current, taken). It is instantiated once on the update path.

## Test plan
- Reset, then lookup PC 0x100 -> `pred_taken_o` = 0. Resolve BEQ at 0x100 with eq = 1, pred = 0 -> next cycle `redirect_o` = 1, `redirect_pc_o` = target 0x80. Lookup 0x100 one cycle later -> `pred_taken_o` = 1.
- Three BNE resolves at 0x200 with eq = 0, then four with eq = 1 -> counter goes 01→10→11→11 (saturates), then 10→01→00→00. The redirect pattern matches each pred-vs-actual pair.
- funct3 = 110 -> `br_unsigned_o` = 1. funct3 = 100 -> 0. BLTU with less = 1 and pred = 1 -> no redirect.
- Resolve at PC 0xFFFFFFFC, BGE with less = 1 (not taken), pred = 1 -> `redirect_pc_o` = 0x00000000.
- Resolve with funct3 = 010 -> counter unchanged, no redirect, stats unchanged. Assert `rst_i` during a mispredicting resolve -> `redirect_o` stays 0.
- With `BRPRED_STATS_EN`: 5 resolves including 2 mispredicts -> `stat_branches_o` = 5, `stat_mispredicts_o` = 2. Without the macro: both read 0.
